// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and the latched command.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

package mem_arb_pkg;

  localparam int unsigned PTR_W  = `ADDR_SIZE;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              r;
    logic              w;
    logic              wt;
    logic              rt;
    logic [PTR_W-1:0]  ptr;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest pending index at or after last+1, with wrap.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic               any_o,
  output logic [ID_W-1:0]    winner_o
);

  localparam int unsigned N = NUM_REQ;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int unsigned          start;
  int unsigned          off;
  int unsigned          pick;
  logic                 found;

  // Rotate the doubled request vector so last+1 sits at bit 0, then priority-encode.
  always_comb begin
    start = 0;
    off   = 0;
    pick  = 0;
    found = 1'b0;
    if (32'(last_i) < N - 1) begin
      start = 32'(last_i) + 1;
    end
    dbl = {req_i, req_i};
    rot = NUM_REQ'(dbl >> start);
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = j;
      end
    end
    pick = start + off;
    if (pick >= N) begin
      pick = pick - N;
    end
    any_o    = |req_i;
    winner_o = ID_W'(pick);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one mem_handle port among NUM_REQ requesters.
// ADDR_W is expected to equal `ADDR_SIZE, the pointer width of the command struct.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = `ADDR_SIZE,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [NUM_REQ-1:0]      req_r_en,
  input  logic [NUM_REQ-1:0]      req_w_en,
  input  logic [NUM_REQ-1:0]      req_write_through,
  input  logic [NUM_REQ-1:0]      req_read_through,
  input  logic [NUM_REQ*ADDR_W-1:0] req_ptr,
  input  logic [NUM_REQ*32-1:0]   req_data_store,
  output logic [31:0]             req_data_load,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    mem_r_en,
  output logic                    mem_w_en,
  output logic                    mem_write_through,
  output logic                    mem_read_through,
  output logic [ADDR_W-1:0]       mem_ptr,
  output logic [31:0]             mem_data_store,
  input  logic [31:0]             mem_data_load,
  input  logic                    mem_done,
  output logic                    grant_valid,
  output logic [ID_W-1:0]         grant_id
);

  arb_state_t         state_q;
  mem_cmd_t           cmd_q;
  mem_cmd_t           cmd_d;
  logic [31:0]        load_q;
  logic [ID_W-1:0]    gid_q;
  logic [ID_W-1:0]    last_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] pending;
  logic [ID_W-1:0]    winner;
  logic               any_req;
  logic               resp_exit;

  assign pending = req_r_en | req_w_en;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i    (pending),
    .last_i   (last_q),
    .any_o    (any_req),
    .winner_o (winner)
  );

  // Command the current winner would latch; a write request overrides a read.
  always_comb begin
    cmd_d      = '0;
    cmd_d.w    = req_w_en[winner];
    cmd_d.r    = req_r_en[winner] & ~req_w_en[winner];
    cmd_d.wt   = req_write_through[winner];
    cmd_d.rt   = req_read_through[winner];
    cmd_d.ptr  = PTR_W'(req_ptr[int'(winner)*ADDR_W +: ADDR_W]);
    cmd_d.data = req_data_store[int'(winner)*32 +: 32];
  end

  // Owner has dropped its request and the port has left its done state.
  assign resp_exit = ~req_r_en[gid_q] & ~req_w_en[gid_q] & ~mem_done;

  // Arbitration FSM with command, load data, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      load_q  <= '0;
      gid_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      done_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            cmd_q   <= cmd_d;
            gid_q   <= winner;
            last_q  <= winner;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_done) begin
            load_q        <= mem_data_load;
            done_q        <= '0;
            done_q[gid_q] <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (resp_exit) begin
            done_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_r_en          = (state_q == ISSUE) & cmd_q.r;
  assign mem_w_en          = (state_q == ISSUE) & cmd_q.w;
  assign mem_write_through = cmd_q.wt;
  assign mem_read_through  = cmd_q.rt;
  assign mem_ptr           = ADDR_W'(cmd_q.ptr);
  assign mem_data_store    = cmd_q.data;
  assign req_data_load     = load_q;
  assign req_done          = done_q;
  assign grant_valid       = (state_q != IDLE);
  assign grant_id          = gid_q;

endmodule
